// File: rtl/axi_burst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_fetch
// Description : AXI4 read-only instruction fetch unit. Issues line-aligned
//               INCR bursts, splits each data beat into instruction words
//               tagged with their PC and queues them in a multi-push FIFO
//               with a valid/ready head. Handles PC redirect (flush), halt
//               on an all-zero beat and a sticky error on non-OKAY responses.
//               Optional macro FETCH_PERF_EN adds perf_bursts / perf_stall.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_fetch #(
    parameter int ID_WIDTH    = 13,
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int BURST_LEN   = 8,
    parameter int FIFO_DEPTH  = 32,
    parameter int AXI_ID      = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_pc,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic [ID_WIDTH-1:0]    m_axi_arid,
    output logic [ADDR_WIDTH-1:0]  m_axi_araddr,
    output logic [7:0]             m_axi_arlen,
    output logic [2:0]             m_axi_arsize,
    output logic [1:0]             m_axi_arburst,
    output logic                   m_axi_arvalid,
    input  logic                   m_axi_arready,
    input  logic [ID_WIDTH-1:0]    m_axi_rid,
    input  logic [DATA_WIDTH-1:0]  m_axi_rdata,
    input  logic [1:0]             m_axi_rresp,
    input  logic                   m_axi_rlast,
    input  logic                   m_axi_rvalid,
    output logic                   m_axi_rready,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   halted,
`ifdef FETCH_PERF_EN
    output logic [31:0]            perf_bursts,
    output logic [31:0]            perf_stall,
`endif
    output logic                   fetch_err
);

    localparam int BPB    = DATA_WIDTH / 8;            // bytes per beat
    localparam int IB     = INSTR_WIDTH / 8;           // bytes per instruction
    localparam int WPB    = DATA_WIDTH / INSTR_WIDTH;  // words per beat
    localparam int LB     = BURST_LEN * BPB;           // line bytes
    localparam int WPL    = BURST_LEN * WPB;           // words per line
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic [2:0]             state_q,      state_d;
    logic [ADDR_WIDTH-1:0]  fpc_q,        fpc_d;
    logic [ADDR_WIDTH-1:0]  line_q,       line_d;
    logic [BEAT_W-1:0]      beat_q,       beat_d;
    logic                   ar_hold_q,    ar_hold_d;
    logic [ADDR_WIDTH-1:0]  araddr_q,     araddr_d;
    logic                   halt_pend_q,  halt_pend_d;
    logic                   redir_pend_q, redir_pend_d;
    logic                   err_q,        err_d;
    logic [PTR_W-1:0]       rd_ptr_q,     rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q,     wr_ptr_d;
    logic [CNT_W-1:0]       count_q,      count_d;

    logic [INSTR_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  fifo_pc_q   [FIFO_DEPTH];

    logic                   credit_ok;
    logic                   ar_fire;
    logic                   r_fire;
    logic                   pop;
    logic                   beat_zero;
    logic                   beat_ok;
    logic [ADDR_WIDTH-1:0]  word_addr [WPB];
    logic [WPB-1:0]         push_mask;
    logic [CNT_W-1:0]       push_ofs  [WPB];
    logic [CNT_W-1:0]       n_push;
    logic                   unused_rid;

    assign unused_rid = ^m_axi_rid;
    assign credit_ok  = (CNT_W'(FIFO_DEPTH) - count_q) >= CNT_W'(WPL);
    assign ar_fire    = m_axi_arvalid && m_axi_arready;
    assign r_fire     = m_axi_rvalid && m_axi_rready;
    assign pop        = instr_valid && instr_ready && !redirect_valid;
    // An error response is handled exactly like an all-zero beat.
    assign beat_zero  = (m_axi_rdata == '0) || (m_axi_rresp != 2'b00);
    assign beat_ok    = (state_q == S_DATA) && r_fire && !redirect_valid &&
                        !halt_pend_q && !beat_zero;

    // Split the current beat into words and pack the kept ones contiguously.
    always_comb begin
        n_push = '0;
        for (int k = 0; k < WPB; k++) begin
            word_addr[k] = line_q + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(BPB) +
                           ADDR_WIDTH'(k * IB);
            push_mask[k] = beat_ok && (word_addr[k] >= fpc_q);
            push_ofs[k]  = n_push;
            n_push       = n_push + CNT_W'(push_mask[k]);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            fpc_q        <= '0;
            line_q       <= '0;
            beat_q       <= '0;
            ar_hold_q    <= 1'b0;
            araddr_q     <= '0;
            halt_pend_q  <= 1'b0;
            redir_pend_q <= 1'b0;
            err_q        <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fpc_q        <= fpc_d;
            line_q       <= line_d;
            beat_q       <= beat_d;
            ar_hold_q    <= ar_hold_d;
            araddr_q     <= araddr_d;
            halt_pend_q  <= halt_pend_d;
            redir_pend_q <= redir_pend_d;
            err_q        <= err_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage: up to WPB writes per cycle at consecutive slots.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WPB; k++) begin
            if (push_mask[k]) begin
                fifo_data_q[wr_ptr_q + push_ofs[k][PTR_W-1:0]] <=
                    m_axi_rdata[k*INSTR_WIDTH +: INSTR_WIDTH];
                fifo_pc_q[wr_ptr_q + push_ofs[k][PTR_W-1:0]] <= word_addr[k];
            end
        end
    end

    // Next-state and datapath update; redirect overrides at the end.
    always_comb begin
        state_d      = state_q;
        fpc_d        = fpc_q;
        line_d       = line_q;
        beat_d       = beat_q;
        ar_hold_d    = ar_hold_q;
        araddr_d     = araddr_q;
        halt_pend_d  = halt_pend_q;
        redir_pend_d = redir_pend_q;
        err_d        = err_q;
        count_d      = count_q + n_push - CNT_W'(pop);
        wr_ptr_d     = wr_ptr_q + n_push[PTR_W-1:0];
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ADDR;
                    fpc_d   = start_pc;
                end
            end
            S_ADDR: begin
                if (ar_fire) begin
                    line_d       = m_axi_araddr;
                    beat_d       = '0;
                    halt_pend_d  = 1'b0;
                    ar_hold_d    = 1'b0;
                    redir_pend_d = 1'b0;
                    state_d      = (redir_pend_q || redirect_valid) ? S_DRAIN : S_DATA;
                end else begin
                    // Once raised, AR stays stable until accepted.
                    ar_hold_d = m_axi_arvalid;
                    araddr_d  = m_axi_araddr;
                    if (redirect_valid && m_axi_arvalid) begin
                        redir_pend_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (r_fire) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if (m_axi_rresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (beat_zero) begin
                        halt_pend_d = 1'b1;
                    end
                    if (m_axi_rlast) begin
                        fpc_d   = line_q + ADDR_WIDTH'(LB);
                        state_d = (halt_pend_q || beat_zero) ? S_HALT : S_ADDR;
                    end
                end
            end
            S_DRAIN: begin
                if (r_fire && m_axi_rlast) begin
                    state_d = S_ADDR;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (redirect_valid) begin
            fpc_d    = redirect_pc;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            if (state_q == S_IDLE || state_q == S_HALT) begin
                state_d = S_ADDR;
            end else if (state_q == S_DATA) begin
                state_d = (r_fire && m_axi_rlast) ? S_ADDR : S_DRAIN;
            end
        end
    end

    // Output decode from registered state.
    always_comb begin
        m_axi_arid    = ID_WIDTH'(AXI_ID);
        m_axi_arlen   = 8'(BURST_LEN - 1);
        m_axi_arsize  = 3'($clog2(BPB));
        m_axi_arburst = 2'b01;
        m_axi_arvalid = (state_q == S_ADDR) && (ar_hold_q || credit_ok);
        m_axi_araddr  = ar_hold_q ? araddr_q : (fpc_q & ~ADDR_WIDTH'(LB - 1));
        m_axi_rready  = (state_q == S_DATA) || (state_q == S_DRAIN);
        instr_valid   = (count_q != '0);
        instr_data    = fifo_data_q[rd_ptr_q];
        instr_pc      = fifo_pc_q[rd_ptr_q];
        halted        = (state_q == S_HALT);
        fetch_err     = err_q;
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_bursts_q, perf_bursts_d;
    logic [31:0] perf_stall_q,  perf_stall_d;

    // Saturating burst and credit-stall counters.
    always_comb begin
        perf_bursts_d = perf_bursts_q;
        perf_stall_d  = perf_stall_q;
        if (ar_fire && perf_bursts_q != 32'hFFFF_FFFF) begin
            perf_bursts_d = perf_bursts_q + 32'd1;
        end
        if (state_q == S_ADDR && !m_axi_arvalid && perf_stall_q != 32'hFFFF_FFFF) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_bursts_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_bursts_q <= perf_bursts_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_bursts = perf_bursts_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_burst_fetch
// Description : Self-checking bench for axi_burst_fetch with a randomized AXI
//               slave, a randomized consumer and a sequential-PC reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_burst_fetch;

    localparam int BL = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [63:0] start_pc = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic [12:0] m_axi_arid;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [12:0] m_axi_rid = '0;
    logic [63:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [63:0] instr_pc;
    logic        halted;
    logic        fetch_err;

    axi_burst_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .start_pc       (start_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .m_axi_arid     (m_axi_arid),
        .m_axi_araddr   (m_axi_araddr),
        .m_axi_arlen    (m_axi_arlen),
        .m_axi_arsize   (m_axi_arsize),
        .m_axi_arburst  (m_axi_arburst),
        .m_axi_arvalid  (m_axi_arvalid),
        .m_axi_arready  (m_axi_arready),
        .m_axi_rid      (m_axi_rid),
        .m_axi_rdata    (m_axi_rdata),
        .m_axi_rresp    (m_axi_rresp),
        .m_axi_rlast    (m_axi_rlast),
        .m_axi_rvalid   (m_axi_rvalid),
        .m_axi_rready   (m_axi_rready),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .halted         (halted),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory image: each word is derived from its own address, never zero.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[31:2], 2'b01};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // ---------------- AXI slave model ----------------
    logic [63:0] ar_log[$];
    logic [63:0] sl_line = '0;
    logic [63:0] sl_ar_addr = '0;
    logic [63:0] beat_addr;
    int          sl_beat = 0;
    bit          sl_busy = 0, sl_ar_acc = 0, sl_r_acc = 0;
    int          gap_mode = 1;
    logic [63:0] zero_addr = '1;
    logic [63:0] err_addr  = '1;
    int          first_acc_cyc = -1;

    function automatic logic [63:0] ar_at(input int i);
        return (ar_log.size() > i) ? ar_log[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    always begin
        @(negedge clk);
        #1;
        if (!reset) begin
            sl_busy = 0; sl_ar_acc = 0; sl_r_acc = 0;
            m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
            m_axi_rdata = '0; m_axi_rresp = '0;
        end else begin
            if (sl_r_acc) begin
                sl_beat++;
                if (sl_beat == BL) sl_busy = 0;
            end
            if (sl_ar_acc) begin
                ar_log.push_back(sl_ar_addr);
                sl_busy = 1; sl_line = sl_ar_addr; sl_beat = 0;
                m_axi_rid = m_axi_arid;
            end
            m_axi_arready = (gap_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
            if (sl_busy && (gap_mode == 0 || $urandom_range(0, 2) != 0)) begin
                beat_addr    = sl_line + 64'(sl_beat * 8);
                m_axi_rvalid = 1;
                m_axi_rlast  = (sl_beat == BL - 1);
                m_axi_rdata  = {mem_word(beat_addr + 64'd4), mem_word(beat_addr)};
                m_axi_rresp  = 2'b00;
                if (beat_addr == zero_addr) m_axi_rdata = '0;
                if (beat_addr == err_addr)  m_axi_rresp = 2'b10;
            end else begin
                m_axi_rvalid = 0;
                m_axi_rlast  = 0;
            end
            sl_ar_acc  = m_axi_arvalid && m_axi_arready;
            sl_ar_addr = m_axi_araddr;
            sl_r_acc   = m_axi_rvalid && m_axi_rready;
            if (sl_r_acc && first_acc_cyc < 0) first_acc_cyc = cyc + 1;
        end
    end

    // ---------------- consumer + reference model ----------------
    logic [63:0] exp_pc = '0;
    logic [63:0] last_pc = '0;
    logic [63:0] first_pc = '0;
    logic [63:0] lim = '0;
    bit          lim_en = 0, first_pend = 1, cons_stall = 0;
    int          pops = 0;
    int          first_valid_cyc = -1;

    always begin
        @(negedge clk);
        #3;
        if (!reset) begin
            instr_ready = 0;
        end else begin
            instr_ready = cons_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (redirect_valid) begin
                exp_pc = redirect_pc;
                first_pend = 1;
            end else if (instr_valid && instr_ready) begin
                check("pop_pc", instr_pc, exp_pc);
                check("pop_data", 64'(instr_data), 64'(mem_word(exp_pc)));
                if (lim_en) check("pop_before_halt", 64'(instr_pc < lim), 64'd1);
                if (first_pend) begin first_pc = instr_pc; first_pend = 0; end
                last_pc = instr_pc;
                pops++;
                exp_pc = exp_pc + 64'd4;
            end
        end
    end

    task automatic do_reset();
        reset = 0; start = 0; redirect_valid = 0; cons_stall = 0; lim_en = 0;
        zero_addr = '1; err_addr = '1; gap_mode = 1;
        repeat (3) tick();
        ar_log.delete();
        pops = 0; first_pend = 1; first_valid_cyc = -1; first_acc_cyc = -1;
        reset = 1;
        tick();
    endtask

    task automatic do_start(input logic [63:0] pc);
        start = 1; start_pc = pc; exp_pc = pc;
        tick();
        start = 0;
    endtask

    initial begin
        // Test 1: reset state, AR fields, aligned start, latency.
        do_reset();
        check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check("rst_araddr", m_axi_araddr, 64'd0);
        check("rst_rready", 64'(m_axi_rready), 64'd0);
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_fetch_err", 64'(fetch_err), 64'd0);
        do_start(64'h1000);
        check("t1_arvalid_latency", 64'(m_axi_arvalid), 64'd1);
        check("t1_araddr", m_axi_araddr, 64'h1000);
        check("t1_arlen", 64'(m_axi_arlen), 64'd7);
        check("t1_arsize", 64'(m_axi_arsize), 64'd3);
        check("t1_arburst", 64'(m_axi_arburst), 64'd1);
        check("t1_arid", 64'(m_axi_arid), 64'd0);
        for (int i = 0; i < 1000 && pops < 16; i++) tick();
        check("t1_pops", 64'(pops), 64'd16);
        check("t1_last_pc", last_pc, 64'h103C);
        check("t1_ar0", ar_at(0), 64'h1000);
        check("t1_r_to_valid", 64'(first_valid_cyc), 64'(first_acc_cyc));

        // Test 2: unaligned start drops leading words.
        do_reset();
        do_start(64'h1014);
        for (int i = 0; i < 1000 && pops < 11; i++) tick();
        check("t2_first_pc", first_pc, 64'h1014);
        check("t2_last_pc", last_pc, 64'h103C);
        for (int i = 0; i < 1000 && ar_log.size() < 2; i++) tick();
        check("t2_ar0", ar_at(0), 64'h1000);
        check("t2_ar1", ar_at(1), 64'h1040);

        // Test 3: stalled consumer, credit throttling.
        do_reset();
        cons_stall = 1;
        do_start(64'h1000);
        repeat (100) tick();
        check("t3_full_valid", 64'(instr_valid), 64'd1);
        check("t3_arvalid_low", 64'(m_axi_arvalid), 64'd0);
        check("t3_ar_count", 64'(ar_log.size()), 64'd2);
        cons_stall = 0;
        for (int i = 0; i < 3000 && pops < 48; i++) tick();
        check("t3_pops", 64'(pops), 64'd48);
        check("t3_last_pc", last_pc, 64'h10BC);

        // Test 4: redirect during beat 3.
        do_reset();
        gap_mode = 0;
        do_start(64'h1000);
        begin
            bit found = 0;
            for (int i = 0; i < 200 && !found; i++) begin
                if (sl_busy && sl_line == 64'h1000 && sl_beat == 3 &&
                    m_axi_rvalid && m_axi_rready) found = 1;
                else tick();
            end
            check("t4_beat3_seen", 64'(found), 64'd1);
        end
        redirect_valid = 1; redirect_pc = 64'h2000;
        tick();
        redirect_valid = 0;
        for (int i = 0; i < 500 && first_pend; i++) tick();
        check("t4_first_pc", first_pc, 64'h2000);
        check("t4_ar1", ar_at(1), 64'h2000);

        // Test 5: all-zero beat 5 halts.
        do_reset();
        zero_addr = 64'h1028; lim = 64'h1028; lim_en = 1;
        do_start(64'h1000);
        for (int i = 0; i < 500 && !halted; i++) tick();
        check("t5_halted", 64'(halted), 64'd1);
        repeat (30) tick();
        check("t5_pops", 64'(pops), 64'd10);
        check("t5_last_pc", last_pc, 64'h1024);
        check("t5_empty", 64'(instr_valid), 64'd0);
        check("t5_ar_count", 64'(ar_log.size()), 64'd1);
        check("t5_no_err", 64'(fetch_err), 64'd0);

        // Test 6: error response on beat 2.
        do_reset();
        err_addr = 64'h1010; lim = 64'h1010; lim_en = 1;
        do_start(64'h1000);
        for (int i = 0; i < 500 && !halted; i++) tick();
        check("t6_fetch_err", 64'(fetch_err), 64'd1);
        check("t6_halted", 64'(halted), 64'd1);
        repeat (30) tick();
        check("t6_pops", 64'(pops), 64'd4);
        check("t6_last_pc", last_pc, 64'h100C);

        // Test 7: redirect out of halt keeps the error flag.
        lim_en = 0; err_addr = '1;
        redirect_valid = 1; redirect_pc = 64'h3000;
        tick();
        redirect_valid = 0;
        check("t7_halted_clr", 64'(halted), 64'd0);
        check("t7_err_kept", 64'(fetch_err), 64'd1);
        for (int i = 0; i < 500 && first_pend; i++) tick();
        check("t7_first_pc", first_pc, 64'h3000);
        check("t7_ar1", ar_at(1), 64'h3000);
        check("t7_err_final", 64'(fetch_err), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
